// File: rtl/a2d_sched.sv
// ---------------------------------------------------------------------------
// a2d_sched
//   Round-robin conversion scheduler for the external 8-channel A2D.
//   A free-running interval timer fires one conversion per period. Each
//   conversion is two SPI transactions: the first issues the channel
//   command, the second clocks back the result. Channels rotate through
//   battery, current, brake and torque.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   done       SPI master transaction complete (1-cycle pulse)
//   rd_data    SPI MISO word, valid with done
//   wrt        start SPI transaction (1-cycle pulse)
//   cmd        SPI MOSI word, held from wrt until the next trigger
//   batt       last battery conversion (ch0)
//   curr       last motor current conversion (ch1)
//   brake      last brake-lever conversion (ch3)
//   torque     last pedal torque conversion (ch4)
//   cnv_cmplt  1-cycle pulse when a result register updates
// ---------------------------------------------------------------------------
module a2d_sched #(
   parameter bit FAST_SIM = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        done,
   input  logic [15:0] rd_data,
   output logic        wrt,
   output logic [15:0] cmd,
   output logic [11:0] batt,
   output logic [11:0] curr,
   output logic [11:0] brake,
   output logic [11:0] torque,
   output logic        cnv_cmplt
);

   typedef enum logic [1:0] {IDLE, CMD, PAUSE, READ} state_t;

   state_t      state;
   logic [13:0] tmr;
   logic [1:0]  rr;
   logic [2:0]  chnl;
   logic        tmr_full;

   // Upper nibble of the MISO word carries no conversion data.
   logic unused_rd_hi;
   assign unused_rd_hi = ^rd_data[15:12];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tmr <= '0;
      else        tmr <= tmr + 14'd1;
   end

   // FAST_SIM shortens the period to 512 clocks for simulation.
   assign tmr_full = FAST_SIM ? (&tmr[8:0]) : (&tmr);

   // Channel 2 is unused on the board, so rr skips it.
   always_comb begin
      chnl = 3'd0;
      unique case (rr)
         2'd0: chnl = 3'd0;
         2'd1: chnl = 3'd1;
         2'd2: chnl = 3'd3;
         2'd3: chnl = 3'd4;
         default: chnl = 3'd0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rr        <= 2'd0;
         wrt       <= 1'b0;
         cmd       <= 16'h0000;
         batt      <= 12'h000;
         curr      <= 12'h000;
         brake     <= 12'h000;
         torque    <= 12'h000;
         cnv_cmplt <= 1'b0;
      end else begin
         wrt       <= 1'b0;
         cnv_cmplt <= 1'b0;
         case (state)
            IDLE: begin
               // Triggers that land outside IDLE are dropped, not queued.
               if (tmr_full) begin
                  wrt   <= 1'b1;
                  cmd   <= {2'b00, chnl, 11'h000};
                  state <= CMD;
               end
            end
            CMD: begin
               if (done) state <= PAUSE;
            end
            PAUSE: begin
               // Same cmd word is resent; the A2D ignores it on the read pass.
               wrt   <= 1'b1;
               state <= READ;
            end
            READ: begin
               if (done) begin
                  case (rr)
                     2'd0: batt   <= rd_data[11:0];
                     2'd1: curr   <= rd_data[11:0];
                     2'd2: brake  <= rd_data[11:0];
                     2'd3: torque <= rd_data[11:0];
                     default: ;
                  endcase
                  cnv_cmplt <= 1'b1;
                  rr        <= rr + 2'd1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_a2d_sched.sv
module tb_a2d_sched;

   logic        clk = 1'b0;
   logic        rst_n, rst_n_s;
   logic        done, done_s;
   logic [15:0] rd_data, rd_data_s;
   logic        wrt, wrt_s;
   logic [15:0] cmd, cmd_s;
   logic [11:0] batt, curr, brake, torque;
   logic [11:0] batt_s, curr_s, brake_s, torque_s;
   logic        cnv_cmplt, cnv_cmplt_s;

   always #5 clk = ~clk;

   a2d_sched #(.FAST_SIM(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .done(done), .rd_data(rd_data),
      .wrt(wrt), .cmd(cmd), .batt(batt), .curr(curr), .brake(brake),
      .torque(torque), .cnv_cmplt(cnv_cmplt)
   );

   a2d_sched #(.FAST_SIM(1'b0)) dut_s (
      .clk(clk), .rst_n(rst_n_s), .done(done_s), .rd_data(rd_data_s),
      .wrt(wrt_s), .cmd(cmd_s), .batt(batt_s), .curr(curr_s), .brake(brake_s),
      .torque(torque_s), .cnv_cmplt(cnv_cmplt_s)
   );

   int n_vec = 0;
   int n_err = 0;
   bit slow_fin = 0;

   // Clocks since the fast instance left reset.
   int cyc;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   typedef struct {
      int          idx;
      logic [11:0] val;
   } exp_t;
   exp_t sbq[$];

   logic [11:0] mdl [4];

   typedef struct {
      logic [15:0] rd;
      logic [15:0] exp_cmd;
      int          idx;
      int          exp_cyc;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [11:0] get_reg(input int idx);
      case (idx)
         0: return batt;
         1: return curr;
         2: return brake;
         default: return torque;
      endcase
   endfunction

   task automatic chk_regs(input string name);
      for (int i = 0; i < 4; i++) chk($sformatf("%s_reg%0d", name, i), get_reg(i), mdl[i]);
   endtask

   task automatic wait_wrt(output bit ok);
      ok = 0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (wrt) begin
            ok = 1;
            break;
         end
      end
      if (!ok) chk("wrt_timeout", 32'd0, 32'd1);
   endtask

   // One full conversion against the SPI model. exp_cyc < 0 skips the timing check.
   task automatic convert(input vec_t v, input int lat, input bit pause_glitch);
      bit ok;
      int extra;
      exp_t e;
      wait_wrt(ok);
      if (!ok) return;
      if (v.exp_cyc >= 0) chk("wrt1_cycle", cyc, v.exp_cyc);
      chk("cmd1", cmd, v.exp_cmd);
      extra = 0;
      for (int i = 0; i < lat; i++) begin
         @(negedge clk);
         extra += int'(wrt);
      end
      chk("no_extra_wrt_cmd", extra, 0);
      chk("cmd_hold_cmd", cmd, v.exp_cmd);
      done = 1'b1;
      rd_data = 16'hDEAD;
      @(negedge clk);
      if (pause_glitch) rd_data = 16'h0DDD;
      else done = 1'b0;
      chk("wrt_gap1", wrt, 1'b0);
      @(negedge clk);
      done = 1'b0;
      rd_data = 16'h0000;
      chk("wrt2_gap2", wrt, 1'b1);
      chk("cmd2", cmd, v.exp_cmd);
      if (pause_glitch) begin
         chk("pause_done_cmplt", cnv_cmplt, 1'b0);
         chk_regs("pause_done");
      end
      extra = 0;
      for (int i = 0; i < lat; i++) begin
         @(negedge clk);
         extra += int'(wrt) + int'(cnv_cmplt);
      end
      chk("no_extra_wrt_read", extra, 0);
      done = 1'b1;
      rd_data = v.rd;
      e.idx = v.idx;
      e.val = v.rd[11:0];
      sbq.push_back(e);
      @(negedge clk);
      done = 1'b0;
      rd_data = 16'h0000;
      chk("cnv_cmplt", cnv_cmplt, 1'b1);
      if (cnv_cmplt && sbq.size() > 0) begin
         e = sbq.pop_front();
         mdl[e.idx] = e.val;
         chk_regs("result");
      end
      @(negedge clk);
      chk("cnv_cmplt_single", cnv_cmplt, 1'b0);
   endtask

   task automatic chk_reset_outs(input string name);
      chk({name, "_wrt"}, wrt, 1'b0);
      chk({name, "_cmd"}, cmd, 16'h0000);
      chk({name, "_cmplt"}, cnv_cmplt, 1'b0);
      chk_regs(name);
   endtask

   // FAST_SIM=0 instance: first trigger must not come before 16384 clocks.
   initial begin
      int n;
      bit seen;
      rst_n_s = 1'b0;
      done_s = 1'b0;
      rd_data_s = 16'h0000;
      repeat (3) @(negedge clk);
      rst_n_s = 1'b1;
      seen = 0;
      n = 0;
      for (int i = 1; i <= 20000; i++) begin
         @(negedge clk);
         if (wrt_s) begin
            n = i;
            seen = 1;
            break;
         end
      end
      chk("slow_first_wrt_cycle", n, 16384);
      chk("slow_first_cmd", cmd_s, 16'h0000);
      slow_fin = 1;
   end

   vec_t rot [5];

   initial begin
      bit ok;
      vec_t v;
      int extra;
      rot[0] = '{rd: 16'hF111, exp_cmd: 16'h0000, idx: 0, exp_cyc: 512};
      rot[1] = '{rd: 16'h0222, exp_cmd: 16'h0800, idx: 1, exp_cyc: -1};
      rot[2] = '{rd: 16'hA333, exp_cmd: 16'h1800, idx: 2, exp_cyc: -1};
      rot[3] = '{rd: 16'h0444, exp_cmd: 16'h2000, idx: 3, exp_cyc: -1};
      rot[4] = '{rd: 16'h5555, exp_cmd: 16'h0000, idx: 0, exp_cyc: -1};
      for (int i = 0; i < 4; i++) mdl[i] = 12'h000;

      rst_n = 1'b0;
      done = 1'b0;
      rd_data = 16'h0000;
      repeat (3) @(negedge clk);
      chk_reset_outs("reset");
      rst_n = 1'b1;

      // First conversion: battery, with upper nibble of MISO ignored.
      v = '{rd: 16'hFABC, exp_cmd: 16'h0000, idx: 0, exp_cyc: 512};
      convert(v, 10, 1'b0);

      // Spurious done while idle.
      done = 1'b1;
      rd_data = 16'h0FFF;
      @(negedge clk);
      done = 1'b0;
      rd_data = 16'h0000;
      chk("idle_done_cmplt", cnv_cmplt, 1'b0);
      chk("idle_done_wrt", wrt, 1'b0);
      @(negedge clk);
      chk("idle_done_cmplt2", cnv_cmplt, 1'b0);
      chk("idle_done_wrt2", wrt, 1'b0);
      chk_regs("idle_done");

      // Reset asserted in READ, in the same cycle wrt is high.
      wait_wrt(ok);
      chk("rst_cmd1", cmd, 16'h0800);
      repeat (5) @(negedge clk);
      done = 1'b1;
      rd_data = 16'h0777;
      @(negedge clk);
      done = 1'b0;
      @(negedge clk);
      chk("rst_wrt2", wrt, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) mdl[i] = 12'h000;
      chk_reset_outs("async_rst");
      done = 1'b1;
      @(negedge clk);
      @(negedge clk);
      done = 1'b0;
      rd_data = 16'h0000;
      chk_reset_outs("rst_held");
      rst_n = 1'b1;

      // Full rotation from battery; fifth trigger wraps back to ch0.
      for (int i = 0; i < 5; i++) convert(rot[i], 3 + i, 1'b0);

      // Slow SPI: triggers during CMD/READ are dropped, rr advances once.
      v = '{rd: 16'h1777, exp_cmd: 16'h0800, idx: 1, exp_cyc: -1};
      convert(v, 600, 1'b0);
      v = '{rd: 16'h2888, exp_cmd: 16'h1800, idx: 2, exp_cyc: -1};
      convert(v, 20, 1'b1);
      v = '{rd: 16'h3999, exp_cmd: 16'h2000, idx: 3, exp_cyc: -1};
      convert(v, 4, 1'b0);
      chk("sb_empty", sbq.size(), 0);

      extra = 0;
      while (!slow_fin && extra < 30000) begin
         @(negedge clk);
         extra++;
      end
      if (!slow_fin) chk("slow_timeout", 32'd0, 32'd1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
